score_controller: RTL
=====================

SCORE_CONTROLLER -- requirements
Module: score_controller

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL provide parameter WIN_SCORE, default 9: points needed to win (1..15).
REQ-003 The block SHALL provide parameter HOLD_TICKS, default 60: timing_tick count spent in POINT.
REQ-004 The block SHALL provide parameter GOAL_MARGIN, default 8: goal threshold distance in pixels from each screen edge.
REQ-005 Port clk SHALL be an input, 1 bit: system clock.
REQ-006 Port rst SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-007 Port timing_tick SHALL be an input, 1 bit: single-cycle frame-rate tick, the same tick that drives ball_controller.
REQ-008 Port start_btn SHALL be an input, 1 bit: level, synchronous to clk, debounced upstream.
REQ-009 Port x_ball SHALL be an input, 11 bits: ball left-edge x position from ball_controller.
REQ-010 Port state SHALL be an output, 2 bits: game state, consumed by ball_controller.
REQ-011 Port score_left SHALL be an output, 4 bits: left-player score.
REQ-012 Port score_right SHALL be an output, 4 bits: right-player score.
REQ-013 Port winner SHALL be an output, 2 bits: 00 none, 01 left, 10 right.

Function
REQ-014 The state encoding SHALL be START=00, PLAY=01, POINT=10, GAME_OVER=11, identical to the vga_pkg state constants (play=01).
REQ-015 The block SHALL detect a start press only as a rising edge of start_btn, using a registered previous value; a held level SHALL count as one press.
REQ-016 In START, a press SHALL cause a transition to PLAY on the next clock.
REQ-017 A left goal SHALL be defined as: state==PLAY, timing_tick=1, and x_ball <= GOAL_MARGIN; on it, score_right SHALL increment by 1.
REQ-018 A right goal SHALL be defined as: state==PLAY, timing_tick=1, and x_ball >= HOR_PIXELS-15-GOAL_MARGIN, using 12-bit compare arithmetic; on it, score_left SHALL increment by 1.
REQ-019 If both goal conditions hold in the same cycle, only the left-goal condition SHALL be honoured.
REQ-020 On a goal, if the incremented score equals WIN_SCORE, the next state SHALL be GAME_OVER and winner SHALL be set in the same cycle; otherwise the next state SHALL be POINT.
REQ-021 Scores SHALL saturate at WIN_SCORE and SHALL never wrap.
REQ-022 Exactly one score SHALL change per goal.
REQ-023 A goal SHALL be accepted only in PLAY; because state leaves PLAY on the next clock, a goal is counted exactly once.
REQ-024 The hold counter SHALL be cleared on entry to POINT and SHALL increment on each timing_tick while in POINT.
REQ-025 POINT exit behaviour SHALL be as defined under Configuration.
REQ-026 Start presses in PLAY SHALL be ignored.
REQ-027 In GAME_OVER, a press SHALL clear both scores and winner and cause a transition to START on the next clock.
REQ-028 All outputs SHALL be registered, with a latency of 1 clock from the qualifying input.

Reset
REQ-029 While rst=0, the block SHALL set state=START, score_left=0, score_right=0, winner=00, hold counter=0, and the registered previous start_btn value=1 (so that a button held through reset is not counted as a press).
REQ-030 Reset asserted mid-operation in any state SHALL return the block to the reset values immediately, independent of clk.
REQ-031 Reset SHALL be released synchronously to clk by the upstream reset synchroniser.

Configuration
REQ-032 The behaviour SHALL be selected by macro AUTO_SERVE_EN.
REQ-033 With AUTO_SERVE_EN defined, POINT SHALL go to PLAY on the timing_tick at which the hold counter reaches HOLD_TICKS-1, and start_btn SHALL be ignored in POINT.
REQ-034 Without AUTO_SERVE_EN, POINT SHALL go to PLAY only on a press occurring after the hold counter has reached HOLD_TICKS-1; earlier presses SHALL be ignored, and the counter SHALL stay saturated at HOLD_TICKS-1.

Verification
REQ-035 Reset/start: rst=0, then release; pulse start_btn for 1 cycle -> state START(00), then state PLAY(01) one clock after the edge; all scores 0.
REQ-036 Right goal: PLAY, x_ball=1001, tick -> score_left=1, state=POINT(10); with AUTO_SERVE_EN, after 60 ticks -> state PLAY.
REQ-037 Left goal without tick: PLAY, x_ball=5, timing_tick=0 -> no change; tick=1 -> score_right=1, exactly once even though x_ball stays 5 for 3 further ticks.
REQ-038 Win: score_right=8, left goal -> score_right=9, winner=10, state=GAME_OVER(11); further ticks with x_ball=0 -> scores unchanged.
REQ-039 Restart/held button: GAME_OVER, start_btn held high for 100 cycles -> one transition to START with scores 0; PLAY is entered only after release and a new press.
REQ-040 Async reset mid-POINT: assert rst between clock edges -> state=00 and scores=0 before the next clk edge.

Source files
------------

// File: rtl/score_controller.sv
// Game score and state controller for the pong game: start/serve/goal/win FSM.
// Optional macro AUTO_SERVE_EN: serve automatically after the POINT hold time.
module score_controller #(
    parameter int WIN_SCORE   = 9,
    parameter int HOLD_TICKS  = 60,
    parameter int GOAL_MARGIN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic        start_btn,
    input  logic [10:0] x_ball,
    output logic [1:0]  state,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic [1:0]  winner
);

    localparam int HOR_PIXELS = 1024;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS - 1);
    localparam logic [3:0] WIN4 = 4'(WIN_SCORE);
    localparam logic [11:0] LEFT_LIM = 12'(GOAL_MARGIN);
    localparam logic [11:0] RIGHT_LIM = 12'(HOR_PIXELS - 15 - GOAL_MARGIN);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_PLAY  = 2'b01,
        ST_POINT = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic          btn_prev;
    logic          press;
    logic [11:0]   x12;
    logic          left_goal, right_goal;
    logic [3:0]    sl_inc, sr_inc;
    logic [3:0]    sl_d, sr_d;
    logic [1:0]    win_d;
    logic [HW-1:0] hold_q, hold_d;

    assign state      = state_q;
    assign press      = start_btn & ~btn_prev;
    assign x12        = {1'b0, x_ball};
    assign left_goal  = (state_q == ST_PLAY) && timing_tick && (x12 <= LEFT_LIM);
    assign right_goal = (state_q == ST_PLAY) && timing_tick && !left_goal
                        && (x12 >= RIGHT_LIM);
    assign sl_inc     = (score_left == WIN4) ? score_left : score_left + 4'd1;
    assign sr_inc     = (score_right == WIN4) ? score_right : score_right + 4'd1;

    // State register and previous button level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_START;
            btn_prev <= 1'b1;
        end else begin
            state_q  <= state_d;
            btn_prev <= start_btn;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_START: if (press) state_d = ST_PLAY;
            ST_PLAY: begin
                if (left_goal)
                    state_d = (sr_inc == WIN4) ? ST_OVER : ST_POINT;
                else if (right_goal)
                    state_d = (sl_inc == WIN4) ? ST_OVER : ST_POINT;
            end
            ST_POINT: begin
`ifdef AUTO_SERVE_EN
                if (timing_tick && hold_q == HOLD_MAX) state_d = ST_PLAY;
`else
                if (press && hold_q == HOLD_MAX) state_d = ST_PLAY;
`endif
            end
            ST_OVER: if (press) state_d = ST_START;
            default: state_d = ST_START;
        endcase
    end

    // Next values of scores, winner and hold counter
    always_comb begin
        sl_d   = score_left;
        sr_d   = score_right;
        win_d  = winner;
        hold_d = hold_q;
        unique case (state_q)
            ST_PLAY: begin
                hold_d = '0;
                if (left_goal) begin
                    sr_d = sr_inc;
                    if (sr_inc == WIN4) win_d = 2'b10;
                end else if (right_goal) begin
                    sl_d = sl_inc;
                    if (sl_inc == WIN4) win_d = 2'b01;
                end
            end
            ST_POINT: begin
                if (timing_tick && hold_q != HOLD_MAX)
                    hold_d = hold_q + 1'b1;
            end
            ST_OVER: begin
                if (press) begin
                    sl_d  = '0;
                    sr_d  = '0;
                    win_d = 2'b00;
                end
            end
            default: ;
        endcase
    end

    // Registered scores, winner and hold counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_left  <= '0;
            score_right <= '0;
            winner      <= 2'b00;
            hold_q      <= '0;
        end else begin
            score_left  <= sl_d;
            score_right <= sr_d;
            winner      <= win_d;
            hold_q      <= hold_d;
        end
    end

endmodule
